fifo_bist_ctrl: RTL

// - Parametrised memory BIST controller for the FIFO dual-port RAM; successor to the single-pattern walking-ones generator.
// - Runs a selectable pattern through write and read-back phases, then compares read data in-block.
// - Reports DONE/FAIL, first failing address and a fail count, so the RAM can be tested without an external comparator.

---
 rtl/fifo_bist_pkg.sv | 45 ++++
 rtl/fifo_bist_ctrl_compare.sv | 88 ++++++++
 rtl/fifo_bist_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_bist_pkg.sv
// Shared types and the pattern generator for the FIFO RAM BIST controller.
package fifo_bist_pkg;

    // Widest word/address the pattern function handles; callers truncate.
    localparam int unsigned PAT_DW = 64;
    localparam int unsigned PAT_AW = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    typedef enum logic [1:0] {
        PAT_WALK1   = 2'd0,
        PAT_WALK0   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_ADDR    = 2'd3
    } bist_pattern_t;

    // Data word for one address; walking patterns come from the rotating register.
    function automatic logic [PAT_DW-1:0] bist_pattern(
        input logic [PAT_AW-1:0] addr,
        input logic [PAT_DW-1:0] rot_reg,
        input bist_pattern_t     sel
    );
        logic [PAT_DW-1:0] word;
        word = '0;
        case (sel)
            PAT_WALK1:   word = rot_reg;
            PAT_WALK0:   word = ~rot_reg;
            PAT_CHECKER: begin
                for (int unsigned i = 0; i < PAT_DW; i++) begin
                    word[i] = ~(i[0] ^ addr[0]);
                end
            end
            PAT_ADDR:    word = PAT_DW'(addr);
            default:     word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/fifo_bist_ctrl_compare.sv
// Read-latency alignment pipe plus mismatch capture for the RAM BIST.
module bist_compare #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_expected,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] expected,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ADDR_WIDTH:0]   fail_count
);

    localparam int unsigned CW   = ADDR_WIDTH + 1;
    localparam int unsigned LAST = RD_LATENCY - 1;

    logic                  vld_q  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] exp_q  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];
    logic                  mismatch_c;

    for (genvar g = 0; g < RD_LATENCY; g++) begin : g_stage
        logic                  v_in;
        logic [DATA_WIDTH-1:0] e_in;
        logic [ADDR_WIDTH-1:0] a_in;

        if (g == 0) begin : g_head
            assign v_in = in_valid;
            assign e_in = in_expected;
            assign a_in = in_addr;
        end else begin : g_body
            assign v_in = vld_q[g-1];
            assign e_in = exp_q[g-1];
            assign a_in = addr_q[g-1];
        end

        // One pipe stage; payload only moves with a valid entry so EXPECTED holds after a run.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q[g]  <= 1'b0;
                exp_q[g]  <= '0;
                addr_q[g] <= '0;
            end else if (clear) begin
                vld_q[g]  <= 1'b0;
                exp_q[g]  <= '0;
                addr_q[g] <= '0;
            end else begin
                vld_q[g] <= v_in && !flush;
                if (v_in) begin
                    exp_q[g]  <= e_in;
                    addr_q[g] <= a_in;
                end
            end
        end
    end

    assign expected   = exp_q[LAST];
    assign mismatch_c = vld_q[LAST] && !flush && (rdata != exp_q[LAST]);

    // Sticky fail flag, first failing address and saturating fail count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else if (clear) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else if (mismatch_c) begin
            fail <= 1'b1;
            if (!fail) begin
                fail_addr <= addr_q[LAST];
            end
            if (fail_count != '1) begin
                fail_count <= fail_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_bist_ctrl.sv
// BIST controller for the FIFO dual-port RAM: write pattern, read back, compare.
module fifo_bist_ctrl
    import fifo_bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BIST_EN,
    input  logic                  START,
    input  logic [1:0]            PATTERN,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic                  CTRL_WINC,
    output logic                  CTRL_RINC,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic [ADDR_WIDTH-1:0] READ_ADDR,
    output logic [DATA_WIDTH-1:0] EXPECTED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  FAIL,
    output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [ADDR_WIDTH:0]   FAIL_COUNT
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ROT_INIT  = DATA_WIDTH'(1);
    localparam logic [2:0]            DRAIN_END = 3'(RD_LATENCY);

    bist_state_t           state_q, state_n;
    bist_pattern_t         pat_q, pat_n;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_n;
    logic [DATA_WIDTH-1:0] rot_q, rot_n;
    logic [2:0]            drain_q, drain_n;
    logic                  winc_n, rinc_n, busy_n, done_n;
    logic [ADDR_WIDTH-1:0] addr_n, raddr_n;
    logic [DATA_WIDTH-1:0] data_n, rexp_q, rexp_n;
    logic                  start_c;

    function automatic logic [DATA_WIDTH-1:0] pat_word(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] r,
        input bist_pattern_t         s
    );
        return DATA_WIDTH'(bist_pattern(PAT_AW'(a), PAT_DW'(r), s));
    endfunction

    // State, counters and registered RAM-side outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            pat_q     <= PAT_WALK1;
            cnt_q     <= '0;
            rot_q     <= '0;
            drain_q   <= '0;
            rexp_q    <= '0;
            CTRL_WINC <= 1'b0;
            CTRL_RINC <= 1'b0;
            ADDR      <= '0;
            DATA      <= '0;
            READ_ADDR <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state_q   <= state_n;
            pat_q     <= pat_n;
            cnt_q     <= cnt_n;
            rot_q     <= rot_n;
            drain_q   <= drain_n;
            rexp_q    <= rexp_n;
            CTRL_WINC <= winc_n;
            CTRL_RINC <= rinc_n;
            ADDR      <= addr_n;
            DATA      <= data_n;
            READ_ADDR <= raddr_n;
            BUSY      <= busy_n;
            DONE      <= done_n;
        end
    end

    // Next state and next output values; the rotating register restarts each phase.
    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        cnt_n   = cnt_q;
        rot_n   = rot_q;
        drain_n = drain_q;
        rexp_n  = rexp_q;
        winc_n  = 1'b0;
        rinc_n  = 1'b0;
        addr_n  = ADDR;
        data_n  = DATA;
        raddr_n = READ_ADDR;
        start_c = 1'b0;

        if (!BIST_EN) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        start_c = 1'b1;
                        state_n = ST_WRITE;
                        pat_n   = bist_pattern_t'(PATTERN);
                        cnt_n   = '0;
                        rot_n   = ROT_INIT;
                        winc_n  = 1'b1;
                        addr_n  = '0;
                        data_n  = pat_word('0, ROT_INIT, pat_n);
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_n = ST_READ;
                        cnt_n   = '0;
                        rot_n   = ROT_INIT;
                        rinc_n  = 1'b1;
                        raddr_n = '0;
                        rexp_n  = pat_word('0, ROT_INIT, pat_q);
                    end else begin
                        cnt_n   = cnt_q + ADDR_WIDTH'(1);
                        rot_n   = {rot_q[DATA_WIDTH-2:0], rot_q[DATA_WIDTH-1]};
                        winc_n  = 1'b1;
                        addr_n  = cnt_n;
                        data_n  = pat_word(cnt_n, rot_n, pat_q);
                    end
                end
                ST_READ: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_n = ST_DRAIN;
                        drain_n = '0;
                    end else begin
                        cnt_n   = cnt_q + ADDR_WIDTH'(1);
                        rot_n   = {rot_q[DATA_WIDTH-2:0], rot_q[DATA_WIDTH-1]};
                        rinc_n  = 1'b1;
                        raddr_n = cnt_n;
                        rexp_n  = pat_word(cnt_n, rot_n, pat_q);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_END) begin
                        state_n = ST_DONE;
                    end else begin
                        drain_n = drain_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        busy_n = (state_n == ST_WRITE) || (state_n == ST_READ) || (state_n == ST_DRAIN);
        done_n = (state_n == ST_DONE);
    end

    // Read-data alignment and result capture.
    bist_compare #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_compare (
        .clk         (CLK),
        .rst_n       (RST),
        .clear       (start_c),
        .flush       (!BIST_EN),
        .in_valid    (CTRL_RINC),
        .in_expected (rexp_q),
        .in_addr     (READ_ADDR),
        .rdata       (RDATA),
        .expected    (EXPECTED),
        .fail        (FAIL),
        .fail_addr   (FAIL_ADDR),
        .fail_count  (FAIL_COUNT)
    );

endmodule
